// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
// Holds the state encoding, digit limits and count field positions.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int DIGIT_W  = 4;
  localparam int TENS_MAX = 5;
  localparam int ONES_MAX = 9;

  localparam int SEC_O_LSB = 0;
  localparam int SEC_T_LSB = 4;
  localparam int MIN_O_LSB = 8;
  localparam int MIN_T_LSB = 12;

  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] d,
    input int                 mx
  );
    return (int'(d) > mx) ? DIGIT_W'(mx) : d;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_if.sv
// Control/status bundle between the timer and its controller.
// The controller owns the pulses and preset; the timer owns the status.
interface countdown_timer_bcd_if;
  import timer_pkg::*;

  logic                 tick;
  logic                 load_p;
  logic                 start_p;
  logic                 stop_p;
  logic                 clear_p;
  logic [4*DIGIT_W-1:0] preset;
  logic [4*DIGIT_W-1:0] count;
  logic                 running;
  logic                 done_p;
  logic                 alarm;

  modport master (
    output tick, load_p, start_p, stop_p, clear_p, preset,
    input  count, running, done_p, alarm
  );

  modport slave (
    input  tick, load_p, start_p, stop_p, clear_p, preset,
    output count, running, done_p, alarm
  );

endinterface

// File: rtl/mod_n_down_digit.sv
// One BCD digit counting down from MAX to 0 with wrap and borrow out.
// Load has priority over the decrement enable.
module mod_n_down_digit #(
  parameter int MAX     = 9,
  parameter int DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow
);

  assign borrow = en & (q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= (q == '0) ? DIGIT_W'(MAX) : q - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// MM:SS BCD countdown timer: control FSM, preset clamp, borrow chain,
// expiry detection and the done pulse / alarm level.
module countdown_timer_bcd
  import timer_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  countdown_timer_bcd_if.slave bus
);

  state_t state, nxt;

  logic [4*DIGIT_W-1:0] cnt;
  logic [4*DIGIT_W-1:0] pre_c;
  logic [4*DIGIT_W-1:0] ld_val;
  logic dec, ld, expire, just_exp;
  logic done_q, alarm_q;
  logic e1, e2, e3, b0, b1, b2, unused_borrow;

  assign pre_c[MIN_T_LSB +: DIGIT_W] =
    clamp_digit(bus.preset[MIN_T_LSB +: DIGIT_W], TENS_MAX);
  assign pre_c[MIN_O_LSB +: DIGIT_W] =
    clamp_digit(bus.preset[MIN_O_LSB +: DIGIT_W], ONES_MAX);
  assign pre_c[SEC_T_LSB +: DIGIT_W] =
    clamp_digit(bus.preset[SEC_T_LSB +: DIGIT_W], TENS_MAX);
  assign pre_c[SEC_O_LSB +: DIGIT_W] =
    clamp_digit(bus.preset[SEC_O_LSB +: DIGIT_W], ONES_MAX);

  // stop and clear both beat a same-cycle tick
  assign dec = bus.tick & (state == RUN)
             & ~bus.clear_p & ~bus.stop_p;
  assign ld     = bus.clear_p | (bus.load_p & (state != RUN));
  assign ld_val = bus.clear_p ? '0 : pre_c;
  assign expire = dec & (cnt == 16'h0001);

  assign e1 = b0;
  assign e2 = b1;
  assign e3 = b2;

  mod_n_down_digit #(.MAX(ONES_MAX), .DIGIT_W(DIGIT_W)) u_sec_o (
    .clk, .rst_n, .en(dec), .load(ld),
    .load_val(ld_val[SEC_O_LSB +: DIGIT_W]),
    .q(cnt[SEC_O_LSB +: DIGIT_W]), .borrow(b0)
  );

  mod_n_down_digit #(.MAX(TENS_MAX), .DIGIT_W(DIGIT_W)) u_sec_t (
    .clk, .rst_n, .en(e1), .load(ld),
    .load_val(ld_val[SEC_T_LSB +: DIGIT_W]),
    .q(cnt[SEC_T_LSB +: DIGIT_W]), .borrow(b1)
  );

  mod_n_down_digit #(.MAX(ONES_MAX), .DIGIT_W(DIGIT_W)) u_min_o (
    .clk, .rst_n, .en(e2), .load(ld),
    .load_val(ld_val[MIN_O_LSB +: DIGIT_W]),
    .q(cnt[MIN_O_LSB +: DIGIT_W]), .borrow(b2)
  );

  mod_n_down_digit #(.MAX(TENS_MAX), .DIGIT_W(DIGIT_W)) u_min_t (
    .clk, .rst_n, .en(e3), .load(ld),
    .load_val(ld_val[MIN_T_LSB +: DIGIT_W]),
    .q(cnt[MIN_T_LSB +: DIGIT_W]), .borrow(unused_borrow)
  );

  always_comb begin
    nxt = state;
    if (bus.clear_p) begin
      nxt = IDLE;
    end else if (bus.load_p && state != RUN) begin
      nxt = IDLE;
    end else if (bus.stop_p && state == RUN) begin
      nxt = PAUSE;
    end else if (bus.start_p && (state == IDLE || state == PAUSE)
                 && cnt != '0) begin
      nxt = RUN;
    end else if (expire) begin
      nxt = EXPIRED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      just_exp <= 1'b0;
      done_q   <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state    <= nxt;
      just_exp <= expire;
      done_q   <= just_exp & ~ld;
      alarm_q  <= ld ? 1'b0 : (alarm_q | just_exp);
    end
  end

  assign bus.count   = cnt;
  assign bus.running = (state == RUN);
  assign bus.done_p  = done_q;
  assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for the BCD countdown timer.
module tb_countdown_timer_bcd;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  countdown_timer_bcd_if bus ();

  countdown_timer_bcd dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic t, input logic l, input logic st,
                      input logic sp, input logic c);
    bus.tick    = t;
    bus.load_p  = l;
    bus.start_p = st;
    bus.stop_p  = sp;
    bus.clear_p = c;
    @(posedge clk);
    #1;
    bus.tick    = 1'b0;
    bus.load_p  = 1'b0;
    bus.start_p = 1'b0;
    bus.stop_p  = 1'b0;
    bus.clear_p = 1'b0;
  endtask

  task automatic load(input logic [15:0] p);
    bus.preset = p;
    step(0, 1, 0, 0, 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.count !== 16'h0000 || bus.running !== 1'b0 ||
        bus.alarm !== 1'b0 || bus.done_p !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init got %h/%b/%b/%b exp 0000/0/0/0",
               bus.count, bus.running, bus.alarm, bus.done_p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load(16'h1234);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== 16'h1233 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre got %h/%b exp 1233/1",
               bus.count, bus.running);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.count !== 16'h0000 || bus.running !== 1'b0 ||
        bus.alarm !== 1'b0 || bus.done_p !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got %h/%b/%b/%b exp 0000/0/0/0",
               bus.count, bus.running, bus.alarm, bus.done_p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_borrow;
    load(16'h1000);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== 16'h0959 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL borrow_1 got %h/%b exp 0959/1",
               bus.count, bus.running);
    end
    for (int i = 0; i < 59; i++) step(1, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== 16'h0900) begin
      n_fail++;
      $display("FAIL borrow_59 got %h exp 0900", bus.count);
    end
    step(1, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== 16'h0859) begin
      n_fail++;
      $display("FAIL borrow_min got %h exp 0859", bus.count);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_expiry;
    load(16'h0002);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== 16'h0000 || bus.running !== 1'b0 ||
        bus.done_p !== 1'b0) begin
      n_fail++;
      $display("FAIL exp_zero got %h/%b/%b exp 0000/0/0",
               bus.count, bus.running, bus.done_p);
    end
    step(0, 0, 0, 0, 0);
    n_tests++;
    if (bus.done_p !== 1'b1 || bus.alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL exp_done got %b/%b exp 1/1",
               bus.done_p, bus.alarm);
    end
    step(0, 0, 0, 0, 0);
    n_tests++;
    if (bus.done_p !== 1'b0 || bus.alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL exp_hold got %b/%b exp 0/1",
               bus.done_p, bus.alarm);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    n_tests++;
    if (bus.count !== 16'h0000 || bus.running !== 1'b0 ||
        bus.alarm !== 1'b1 || bus.done_p !== 1'b0) begin
      n_fail++;
      $display("FAIL exp_ticks got %h/%b/%b/%b exp 0000/0/1/0",
               bus.count, bus.running, bus.alarm, bus.done_p);
    end
    step(0, 0, 0, 0, 1);
    n_tests++;
    if (bus.alarm !== 1'b0 || bus.count !== 16'h0000) begin
      n_fail++;
      $display("FAIL exp_clear got %b/%h exp 0/0000",
               bus.alarm, bus.count);
    end
  endtask

  task automatic test_pause;
    load(16'h0030);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    n_tests++;
    if (bus.count !== 16'h0030 || bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_tick got %h/%b exp 0030/0",
               bus.count, bus.running);
    end
    step(0, 0, 1, 0, 0);
    load(16'h1111);
    n_tests++;
    if (bus.count !== 16'h0030 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL load_in_run got %h/%b exp 0030/1",
               bus.count, bus.running);
    end
    step(0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    n_tests++;
    if (bus.count !== 16'h0030 || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL start_tick got %h/%b exp 0030/1",
               bus.count, bus.running);
    end
    step(1, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== 16'h0029) begin
      n_fail++;
      $display("FAIL resume got %h exp 0029", bus.count);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_clamp;
    load(16'h7C9F);
    n_tests++;
    if (bus.count !== 16'h5959 || bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp got %h/%b exp 5959/0",
               bus.count, bus.running);
    end
    load(16'h0000);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== 16'h0000 || bus.running !== 1'b0 ||
        bus.done_p !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_start got %h/%b/%b exp 0000/0/0",
               bus.count, bus.running, bus.done_p);
    end
  endtask

  task automatic test_full_range;
    int pulses;
    pulses = 0;
    load(16'h5959);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    n_tests++;
    if (bus.count !== 16'h5958) begin
      n_fail++;
      $display("FAIL full_first got %h exp 5958", bus.count);
    end
    for (int i = 1; i < 3599; i++) begin
      step(1, 0, 0, 0, 0);
      if (bus.done_p === 1'b1) pulses++;
    end
    n_tests++;
    if (bus.count !== 16'h0000 || bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end got %h/%b exp 0000/0",
               bus.count, bus.running);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      if (bus.done_p === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 1 || bus.alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL full_done got %0d/%b exp 1/1", pulses, bus.alarm);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.tick    = 1'b0;
    bus.load_p  = 1'b0;
    bus.start_p = 1'b0;
    bus.stop_p  = 1'b0;
    bus.clear_p = 1'b0;
    bus.preset  = 16'h0000;
    test_reset;
    test_borrow;
    test_expiry;
    test_pause;
    test_clamp;
    test_full_range;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
